reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin controller that shares one 32-bit enable-loaded register (D/en/Q holding register in the CPU datapath) among `NREQ` requesters. It drives the register's `D` and `en` inputs, issues per-requester grants, and supports locked multi-beat ownership with a bounded burst length so that no requester starves. It sits between the writeback-side producers (ALU result, load unit, PC/CSR update) and the shared register instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `W`, 32: data width; must match the register width.
- `MAXBURST`, 8: maximum consecutive beats in one locked ownership, at least 1.
- `IW`, clog2(`NREQ`): owner-index width; derived, not overridden.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous and active-low (assert = 0).
- `req`  in  NREQ  per-requester write request; held until granted.
- `lock`  in  NREQ  per-requester burst request; sampled with `req`.
- `wdata`  in  NREQ*W  requester i's data in bits [i*W +: W].
- `gnt`  out  NREQ  one-hot beat grant, registered; all zero when no beat.
- `reg_en`  out  1  enable to the shared register; equals OR of `gnt`.
- `reg_d`  out  W  data to the shared register, registered.
- `owner`  out  IW  index of the current or last grantee.
- `busy`  out  1  high while in LOCKED.

## Operation
- States: IDLE, GRANT, LOCKED.
- Arbitration runs at every edge in IDLE and GRANT, and at LOCKED exit. Winner is the first requester with `req` high, searching from `last+1` modulo `NREQ`. `last` is the previous winner and resets to `NREQ-1`, so requester 0 has top priority after reset.
- Winner found: at the edge, `gnt[winner]`=1, `reg_en`=1, `reg_d`=`wdata[winner]`, `owner`=winner, `last`=winner. Next state is LOCKED if `lock[winner]`=1, otherwise GRANT.
- No winner: `gnt`=0, `reg_en`=0; next state IDLE. `reg_d` and `owner` hold their values.
- GRANT lasts one beat. Back-to-back grants to different requesters have no idle bubble.
- LOCKED: each edge where `req[owner]`=1 and `lock[owner]`=1 issues another beat to `owner` and increments the beat counter. Inputs from other requesters are ignored.
- LOCKED exit, at the first edge where any of these holds: `req[owner]`=0, `lock[owner]`=0, or the beat count reaches `MAXBURST`. At that edge normal arbitration runs, with the owner having lowest priority. A forced release at `MAXBURST` lets the same owner win again only if no other `req` is high.
- Requester protocol: a requester keeps `req` and `wdata` stable until it sees `gnt[i]` high. It drops `req` in the cycle after `gnt` if it has no further beat.
- Invariants: `gnt` is zero or one-hot. `reg_en` equals `|gnt`. `busy` is 1 exactly in LOCKED.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `gnt`=0, `reg_en`=0, `reg_d`=0, `owner`=0, `busy`=0, `last`=`NREQ-1`, beat counter=0. Outputs clear immediately, without waiting for a clock.
- Reset asserted mid-burst: the burst is abandoned; no partial beat is issued after release.
- Latency: `req` high at edge k gives `gnt`/`reg_en`/`reg_d` valid after edge k, and the register Q updates at edge k+1.
- Throughput: one beat per cycle, sustained.
- Simultaneous `req` from all requesters: strict rotation, one grant per cycle.

## Structure
- Shared package `arb_pkg` holds:
  - the state enum (IDLE, GRANT, LOCKED);
  - the `clog2` helper;
  - the default values of `NREQ`, `W` and `MAXBURST`.
- One combinational sub-module, `rr_pick`: inputs `req` and `last`, outputs `valid` and the winner index. It is reused for both normal arbitration and LOCKED exit.
- Beat counter is clog2(`MAXBURST`+1) bits wide.

## Test plan
- Reset, then `req`=0001, `wdata[0]`=0xDEADBEEF → one cycle later `gnt`=0001, `reg_en`=1, `reg_d`=0xDEADBEEF. Register Q = 0xDEADBEEF at the next edge.
- `req`=1111 held, no lock, for 8 cycles → grant order 0,1,2,3,0,1,2,3; `gnt` one-hot every cycle, no idle cycles.
- `req`=0110 with `lock`=0010 and `MAXBURST`=8 → requester 1 gets exactly 8 consecutive beats with `busy`=1, then requester 2 is granted in the next cycle.
- Locked burst by requester 3, then drop `lock[3]` after 3 beats → exactly 3 beats are issued; `busy` falls; the next winner is selected among the remaining requests.
- Pull `rst` low during the 2nd beat of a locked burst, between clock edges → `gnt`=0, `reg_en`=0, `reg_d`=0 without a clock edge. After release with `req`=0001, requester 0 is granted first.
- Randomized `req`/`lock` for 10k cycles → `gnt` one-hot-or-zero, `reg_en`==`|gnt`, no requester waits more than (`NREQ`-1)*`MAXBURST`+1 cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the register-write arbiter: FSM states, default sizing,
// and the ceiling-log2 helper used to size index and counter fields.
package arb_pkg;

    localparam int ARB_NREQ     = 4;
    localparam int ARB_W        = 32;
    localparam int ARB_MAXBURST = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first asserted request starting at last+1, wrapping,
// so the previous winner is always the lowest-priority candidate.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ
) (
    input  logic [NREQ-1:0]          req,
    input  logic [clog2(NREQ)-1:0]   last,
    output logic                     valid,
    output logic [clog2(NREQ)-1:0]   idx
);

    localparam int IW = clog2(NREQ);

    function automatic logic [IW-1:0] wrap_idx(input int s);
        return IW'((s >= NREQ) ? s - NREQ : s);
    endfunction

    // Scan from lowest to highest priority so the closest requester overwrites.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid = 1'b0;
        idx   = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[wrap_idx(int'(last) + i)]) begin
                valid = 1'b1;
                idx   = wrap_idx(int'(last) + i);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin owner of a shared enable-loaded register: drives D/en, issues
// one-hot grants and supports locked bursts capped at MAXBURST beats.
module reg_write_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = ARB_NREQ,
    parameter int W        = ARB_W,
    parameter int MAXBURST = ARB_MAXBURST
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*W-1:0]       wdata,
    output logic [NREQ-1:0]         gnt,
    output logic                    reg_en,
    output logic [W-1:0]            reg_d,
    output logic [clog2(NREQ)-1:0]  owner,
    output logic                    busy
);

    localparam int IW = clog2(NREQ);
    localparam int BW = clog2(MAXBURST + 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'(MAXBURST);

    arb_state_e       r_state, w_state_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [W-1:0]     r_reg_d, w_reg_d_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [IW-1:0]    r_last, w_last_nxt;
    logic [BW-1:0]    r_beat, w_beat_nxt;
    logic             w_valid;
    logic [IW-1:0]    w_win;
    logic             w_cont;
    logic [W-1:0]     w_data [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_data[g] = wdata[g*W +: W];
    end

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .last  (r_last),
        .valid (w_valid),
        .idx   (w_win)
    );

    // A locked owner keeps the register only while it still asks and has beats left.
    assign w_cont = (r_state == ST_LOCKED) && req[r_owner] && lock[r_owner]
                    && (r_beat != BEAT_MAX);

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
        w_reg_d_nxt = r_reg_d;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_beat_nxt  = '0;
        if (w_cont) begin
            w_state_nxt          = ST_LOCKED;
            w_gnt_nxt[r_owner]   = 1'b1;
            w_reg_d_nxt          = w_data[r_owner];
            w_beat_nxt           = r_beat + BW'(1);
        end else if (w_valid) begin
            w_gnt_nxt[w_win] = 1'b1;
            w_reg_d_nxt      = w_data[w_win];
            w_owner_nxt      = w_win;
            w_last_nxt       = w_win;
            if (lock[w_win]) begin
                w_state_nxt = ST_LOCKED;
                w_beat_nxt  = BW'(1);
            end else begin
                w_state_nxt = ST_GRANT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_reg_d <= '0;
            r_owner <= '0;
            r_last  <= IW'(NREQ - 1);
            r_beat  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so all update together at the edge.
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_reg_d <= w_reg_d_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_beat  <= w_beat_nxt;
        end
    end

    assign gnt    = r_gnt;
    assign reg_en = |r_gnt;
    assign reg_d  = r_reg_d;
    assign owner  = r_owner;
    assign busy   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed checks of the register-write arbiter plus a randomized invariant and
// starvation run; a local D/en/Q register stands in for the shared register.
module tb_reg_write_arbiter;

    localparam int NREQ     = 4;
    localparam int W        = 32;
    localparam int MAXBURST = 8;
    localparam int IW       = 2;
    localparam int BOUND    = (NREQ - 1) * MAXBURST + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req, lock, gnt;
    logic [NREQ*W-1:0]    wdata;
    logic                 reg_en;
    logic [W-1:0]         reg_d;
    logic [IW-1:0]        owner;
    logic                 busy;
    logic [W-1:0]         q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_write_arbiter #(.NREQ(NREQ), .W(W), .MAXBURST(MAXBURST)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .lock   (lock),
        .wdata  (wdata),
        .gnt    (gnt),
        .reg_en (reg_en),
        .reg_d  (reg_d),
        .owner  (owner),
        .busy   (busy)
    );

    always @(posedge clk or negedge rst) begin
        if (!rst)        q <= '0;
        else if (reg_en) q <= reg_d;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wd(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req   = '0;
        lock  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    int unsigned wait_cnt [NREQ];
    int unsigned max_wait;
    int          viol_onehot, viol_en, viol_spur;
    logic [NREQ-1:0] req_prev;

    initial begin
        // Reset state
        do_reset();
        check("rst_gnt",    gnt,    4'b0000);
        check("rst_reg_en", reg_en, 1'b0);
        check("rst_reg_d",  reg_d,  32'h0);
        check("rst_owner",  owner,  2'd0);
        check("rst_busy",   busy,   1'b0);

        // Single request: one-cycle grant, Q loads at the following edge
        step();
        req = 4'b0001;
        set_wd(0, 32'hDEADBEEF);
        step();
        check("single_gnt",    gnt,    4'b0001);
        check("single_reg_en", reg_en, 1'b1);
        check("single_reg_d",  reg_d,  32'hDEADBEEF);
        check("single_q_pre",  q,      32'h0);
        req = '0;
        step();
        check("single_q_post", q,      32'hDEADBEEF);
        check("single_idle",   reg_en, 1'b0);
        check("single_hold_d", reg_d,  32'hDEADBEEF);

        // All four requesting without lock: strict rotation from requester 0
        do_reset();
        for (int i = 0; i < NREQ; i++) set_wd(i, 32'h1000_0000 + i);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("rr_gnt_%0d", k),   gnt,   4'b0001 << (k % NREQ));
            check($sformatf("rr_reg_d_%0d", k), reg_d, 32'h1000_0000 + (k % NREQ));
        end

        // Requester 1 locks: exactly MAXBURST beats, then requester 2
        req = 4'b0110;
        lock = 4'b0010;
        set_wd(1, 32'hAAAA_0001);
        set_wd(2, 32'hBBBB_0002);
        for (int k = 0; k < MAXBURST; k++) begin
            step();
            check($sformatf("burst_gnt_%0d", k),  gnt,  4'b0010);
            check($sformatf("burst_busy_%0d", k), busy, 1'b1);
        end
        step();
        check("burst_next_gnt",   gnt,   4'b0100);
        check("burst_next_busy",  busy,  1'b0);
        check("burst_next_reg_d", reg_d, 32'hBBBB_0002);
        req = '0;
        lock = '0;
        step();
        check("burst_idle_gnt", gnt, 4'b0000);

        // Requester 3 locks, releases lock after 3 beats while still requesting
        req = 4'b1011;
        lock = 4'b1000;
        set_wd(0, 32'h0000_00A0);
        set_wd(1, 32'h0000_00A1);
        set_wd(3, 32'hCCCC_0003);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("early_gnt_%0d", k),  gnt,  4'b1000);
            check($sformatf("early_busy_%0d", k), busy, 1'b1);
        end
        lock[3] = 1'b0;
        step();
        check("early_exit_gnt",   gnt,   4'b0001);
        check("early_exit_busy",  busy,  1'b0);
        check("early_exit_owner", owner, 2'd0);
        req[0] = 1'b0;
        step();
        check("early_rot_gnt1", gnt, 4'b0010);
        req[1] = 1'b0;
        step();
        check("early_rot_gnt3", gnt,   4'b1000);
        check("early_rot_own3", owner, 2'd3);
        check("early_rot_busy", busy,  1'b0);
        req = '0;
        step();
        check("early_idle_en", reg_en, 1'b0);

        // Reset pulled between edges during the 2nd locked beat
        req = 4'b0001;
        lock = 4'b0001;
        set_wd(0, 32'h5555_0000);
        step();
        check("rstmid_beat1_busy", busy, 1'b1);
        step();
        check("rstmid_beat2_gnt", gnt, 4'b0001);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_gnt",    gnt,    4'b0000);
        check("rstmid_reg_en", reg_en, 1'b0);
        check("rstmid_reg_d",  reg_d,  32'h0);
        check("rstmid_busy",   busy,   1'b0);
        req = 4'b1001;
        lock = '0;
        set_wd(3, 32'h3333_0003);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rstmid_after_gnt",   gnt,   4'b0001);
        check("rstmid_after_owner", owner, 2'd0);
        check("rstmid_after_busy",  busy,  1'b0);
        check("rstmid_after_reg_d", reg_d, 32'h5555_0000);

        // Randomized requesters following the hold-until-granted protocol
        do_reset();
        max_wait    = 0;
        viol_onehot = 0;
        viol_en     = 0;
        viol_spur   = 0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            req_prev = req;
            step();
            if ((gnt & (gnt - 1'b1)) != '0) viol_onehot++;
            if (reg_en !== (|gnt))          viol_en++;
            if ((gnt & ~req_prev) != '0)    viol_spur++;
            for (int i = 0; i < NREQ; i++) begin
                if (req_prev[i]) begin
                    if (gnt[i]) begin
                        wait_cnt[i] = 0;
                    end else begin
                        wait_cnt[i]++;
                        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    end
                end
                if (gnt[i]) begin
                    req[i]  = ($urandom_range(0, 1) == 1);
                    lock[i] = ($urandom_range(0, 2) != 0);
                    set_wd(i, $urandom());
                end else if (!req[i]) begin
                    req[i]  = ($urandom_range(0, 3) == 0);
                    lock[i] = ($urandom_range(0, 1) == 1);
                    wait_cnt[i] = 0;
                end
            end
        end
        check("rand_onehot_viol", 64'(viol_onehot), 64'd0);
        check("rand_reg_en_viol", 64'(viol_en),     64'd0);
        check("rand_spurious",    64'(viol_spur),   64'd0);
        check("rand_wait_bound",  64'(max_wait <= BOUND), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
